// File: rtl/ctrl_mem_pipe.sv
// MEM->WB pipeline control stage: destination decode, WB registers, load wait
// state with stall request, and a writeback history for RAW hazard detection.
module ctrl_mem_pipe #(
    parameter int unsigned RA_W    = 4,
    parameter int unsigned STAGES  = 2,
    parameter int unsigned SP_ADDR = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic              i_valid,
    input  logic [15:0]       i_ir_mem,
    input  logic              i_mem_ready,
    input  logic [RA_W-1:0]   i_src_a,
    input  logic [RA_W-1:0]   i_src_b,
    output logic [15:0]       o_ir_wb_r,
    output logic              o_valid_wb_r,
    output logic [RA_W-1:0]   o_addr_rd_r,
    output logic              o_rd_en_r,
    output logic              o_stall_req,
    output logic [STAGES-1:0] o_hazard_a,
    output logic [STAGES-1:0] o_hazard_b
);

    localparam int unsigned IR_W = 16;
    localparam int unsigned OP_W = 9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    state_e                       state_q, state_d;
    logic [IR_W-1:0]              ir_q, ir_d;
    logic                         valid_q, valid_d;
    logic                         stall_req_q, stall_req_d;
    // Entry 0 is the live WB destination/write-enable; higher entries are older writes.
    logic [STAGES-1:0][RA_W-1:0]  hist_addr_q, hist_addr_d;
    logic [STAGES-1:0]            hist_en_q, hist_en_d;

    logic [OP_W-1:0]              opcode;
    logic                         op_match;
    logic                         op_load;
    logic [RA_W-1:0]              rd_dec;
    logic                         we_dec;
    logic                         load_dec;
    logic                         load_pending;

    assign opcode = i_ir_mem[15:7];

    // Destination register decode from the MEM-stage opcode.
    always_comb begin
        op_match = 1'b0;
        op_load  = 1'b0;
        rd_dec   = '0;
        casez (opcode)
            9'b0001110??: begin
                op_match = 1'b1;
                rd_dec   = RA_W'(i_ir_mem[2:0]);
            end
            9'b10101????: begin
                op_match = 1'b1;
                rd_dec   = RA_W'(i_ir_mem[10:8]);
            end
            9'b101100001: begin
                op_match = 1'b1;
                rd_dec   = RA_W'(SP_ADDR);
            end
            9'b00100????: begin
                op_match = 1'b1;
                rd_dec   = RA_W'(i_ir_mem[10:8]);
            end
            9'b01000110?: begin
                op_match = 1'b1;
                rd_dec   = RA_W'(i_ir_mem[2:0]);
            end
            9'b01101????: begin
                op_match = 1'b1;
                op_load  = 1'b1;
                rd_dec   = RA_W'(i_ir_mem[2:0]);
            end
            9'b01001????: begin
                op_match = 1'b1;
                op_load  = 1'b1;
                rd_dec   = RA_W'(i_ir_mem[10:8]);
            end
            default: begin
                op_match = 1'b0;
            end
        endcase
    end

    assign we_dec       = i_valid & op_match;
    assign load_dec     = we_dec & op_load;
    assign load_pending = load_dec & ~i_mem_ready;

    // Next-state logic; the write enable in entry 0 is a one-cycle pulse by default.
    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        valid_d      = valid_q;
        hist_addr_d  = hist_addr_q;
        hist_en_d    = hist_en_q;
        hist_en_d[0] = 1'b0;

        if (i_flush) begin
            ir_d    = '0;
            valid_d = 1'b0;
            state_d = ST_IDLE;
        end else if (state_q == ST_WAIT) begin
            if (i_mem_ready) begin
                hist_en_d[0] = 1'b1;
                state_d      = ST_IDLE;
            end
        end else if (!i_stall) begin
            for (int unsigned k = 1; k < STAGES; k++) begin
                hist_addr_d[k] = hist_addr_q[k-1];
                hist_en_d[k]   = hist_en_q[k-1];
            end
            ir_d           = i_ir_mem;
            valid_d        = i_valid;
            hist_addr_d[0] = rd_dec;
            hist_en_d[0]   = we_dec & ~load_pending;
            if (load_pending) begin
                state_d = ST_WAIT;
            end
        end

        stall_req_d = (state_d == ST_WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ir_q        <= '0;
            valid_q     <= 1'b0;
            stall_req_q <= 1'b0;
            hist_addr_q <= '0;
            hist_en_q   <= '0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            valid_q     <= valid_d;
            stall_req_q <= stall_req_d;
            hist_addr_q <= hist_addr_d;
            hist_en_q   <= hist_en_d;
        end
    end

    // Hazard flags compare each history entry against the ID-stage sources.
    always_comb begin
        o_hazard_a = '0;
        o_hazard_b = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            o_hazard_a[k] = hist_en_q[k] & (hist_addr_q[k] == i_src_a);
            o_hazard_b[k] = hist_en_q[k] & (hist_addr_q[k] == i_src_b);
        end
    end

    assign o_ir_wb_r    = ir_q;
    assign o_valid_wb_r = valid_q;
    assign o_addr_rd_r  = hist_addr_q[0];
    assign o_rd_en_r    = hist_en_q[0];
    assign o_stall_req  = stall_req_q;

endmodule

// File: tb/tb_ctrl_mem_pipe.sv
// Scoreboard bench for ctrl_mem_pipe: a transaction-level model queues expected
// WB/hazard outputs per cycle; a monitor pops and compares after each rising edge.
module tb_ctrl_mem_pipe;

    localparam int unsigned RA_W    = 4;
    localparam int unsigned STAGES  = 3;
    localparam int unsigned SP_ADDR = 13;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_stall;
    logic              i_flush;
    logic              i_valid;
    logic [15:0]       i_ir_mem;
    logic              i_mem_ready;
    logic [RA_W-1:0]   i_src_a;
    logic [RA_W-1:0]   i_src_b;
    logic [15:0]       o_ir_wb_r;
    logic              o_valid_wb_r;
    logic [RA_W-1:0]   o_addr_rd_r;
    logic              o_rd_en_r;
    logic              o_stall_req;
    logic [STAGES-1:0] o_hazard_a;
    logic [STAGES-1:0] o_hazard_b;

    ctrl_mem_pipe #(.RA_W(RA_W), .STAGES(STAGES), .SP_ADDR(SP_ADDR)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_stall      (i_stall),
        .i_flush      (i_flush),
        .i_valid      (i_valid),
        .i_ir_mem     (i_ir_mem),
        .i_mem_ready  (i_mem_ready),
        .i_src_a      (i_src_a),
        .i_src_b      (i_src_b),
        .o_ir_wb_r    (o_ir_wb_r),
        .o_valid_wb_r (o_valid_wb_r),
        .o_addr_rd_r  (o_addr_rd_r),
        .o_rd_en_r    (o_rd_en_r),
        .o_stall_req  (o_stall_req),
        .o_hazard_a   (o_hazard_a),
        .o_hazard_b   (o_hazard_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]       ir;
        logic              valid;
        logic [RA_W-1:0]   addr;
        logic              en;
        logic              stall;
        logic [STAGES-1:0] haz_a;
        logic [STAGES-1:0] haz_b;
    } exp_t;

    typedef struct {
        logic [RA_W-1:0] addr;
        logic            en;
    } wr_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Reference model: one WB slot, a list of older retired writes, a load-wait flag.
    bit              m_wait;
    logic [15:0]     m_ir;
    logic            m_valid;
    wr_t             m_wb;
    wr_t             m_old[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Instruction table: top-9-bit pattern, care mask, destination source, load flag.
    function automatic void decode(input logic [15:0] ir, output bit hit,
                                   output logic [RA_W-1:0] rd, output bit ld);
        logic [8:0] op;
        op  = ir[15:7];
        hit = 1'b1;
        ld  = 1'b0;
        rd  = '0;
        if      ((op & 9'h1FC) == 9'b000111000) rd = RA_W'(ir[2:0]);
        else if ((op & 9'h1F0) == 9'b101010000) rd = RA_W'(ir[10:8]);
        else if (op == 9'b101100001)            rd = RA_W'(SP_ADDR);
        else if ((op & 9'h1F0) == 9'b001000000) rd = RA_W'(ir[10:8]);
        else if ((op & 9'h1FE) == 9'b010001100) rd = RA_W'(ir[2:0]);
        else if ((op & 9'h1F0) == 9'b011010000) begin rd = RA_W'(ir[2:0]);  ld = 1'b1; end
        else if ((op & 9'h1F0) == 9'b010010000) begin rd = RA_W'(ir[10:8]); ld = 1'b1; end
        else hit = 1'b0;
    endfunction

    task automatic model_reset();
        m_wait  = 1'b0;
        m_ir    = '0;
        m_valid = 1'b0;
        m_wb    = '{addr: '0, en: 1'b0};
        m_old   = {};
        for (int i = 1; i < int'(STAGES); i++) m_old.push_back('{addr: '0, en: 1'b0});
    endtask

    task automatic model_step(input bit r, input bit st, input bit fl, input bit v,
                              input logic [15:0] ir, input bit rdy);
        bit hit, ld;
        logic [RA_W-1:0] rd;
        if (r) begin
            model_reset();
        end else if (fl) begin
            m_ir     = '0;
            m_valid  = 1'b0;
            m_wb.en  = 1'b0;
            m_wait   = 1'b0;
        end else if (m_wait) begin
            m_wb.en = rdy;
            if (rdy) m_wait = 1'b0;
        end else if (st) begin
            m_wb.en = 1'b0;
        end else begin
            if (STAGES > 1) begin
                m_old.push_front(m_wb);
                void'(m_old.pop_back());
            end
            decode(ir, hit, rd, ld);
            m_ir    = ir;
            m_valid = v;
            m_wb    = '{addr: rd, en: v && hit && !(ld && !rdy)};
            m_wait  = v && hit && ld && !rdy;
        end
    endtask

    function automatic logic [STAGES-1:0] model_haz(input logic [RA_W-1:0] src);
        logic [STAGES-1:0] h;
        h    = '0;
        h[0] = m_wb.en && (m_wb.addr == src);
        for (int k = 1; k < int'(STAGES); k++) h[k] = m_old[k-1].en && (m_old[k-1].addr == src);
        return h;
    endfunction

    task automatic step(input bit r, input bit st, input bit fl, input bit v,
                        input logic [15:0] ir, input bit rdy,
                        input logic [RA_W-1:0] sa, input logic [RA_W-1:0] sb);
        exp_t e;
        @(negedge clk);
        rst = r; i_stall = st; i_flush = fl; i_valid = v;
        i_ir_mem = ir; i_mem_ready = rdy; i_src_a = sa; i_src_b = sb;
        model_step(r, st, fl, v, ir, rdy);
        e.ir    = m_ir;
        e.valid = m_valid;
        e.addr  = m_wb.addr;
        e.en    = m_wb.en;
        e.stall = m_wait;
        e.haz_a = model_haz(sa);
        e.haz_b = model_haz(sb);
        exp_q.push_back(e);
    endtask

    // Monitor: compares every registered output one time unit after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ir_wb",    32'(o_ir_wb_r),    32'(e.ir));
            chk("valid_wb", 32'(o_valid_wb_r), 32'(e.valid));
            chk("addr_rd",  32'(o_addr_rd_r),  32'(e.addr));
            chk("rd_en",    32'(o_rd_en_r),    32'(e.en));
            chk("stall_req",32'(o_stall_req),  32'(e.stall));
            chk("hazard_a", 32'(o_hazard_a),   32'(e.haz_a));
            chk("hazard_b", 32'(o_hazard_b),   32'(e.haz_b));
        end
    end

    function automatic logic [15:0] rand_ir();
        logic [15:0] ir;
        ir = 16'($urandom);
        case ($urandom_range(0, 8))
            0: ir[15:9] = 7'b0001110;
            1: ir[15:11] = 5'b10101;
            2: ir[15:7] = 9'b101100001;
            3: ir[15:11] = 5'b00100;
            4: ir[15:8] = 8'b01000110;
            5, 6: ir[15:11] = 5'b01101;
            7: ir[15:11] = 5'b01001;
            default: ;
        endcase
        return ir;
    endfunction

    initial begin
        model_reset();
        rst = 1'b1; i_stall = 1'b0; i_flush = 1'b0; i_valid = 1'b0;
        i_ir_mem = '0; i_mem_ready = 1'b0; i_src_a = '0; i_src_b = '0;

        step(1, 0, 0, 0, 16'h0000, 0, 0, 0);
        step(1, 0, 0, 1, 16'h1C53, 1, 3, 3);

        // ADD r3 then an unknown opcode
        step(0, 0, 0, 1, 16'h1C53, 1, 3, 0);
        step(0, 0, 0, 1, 16'hFFFF, 1, 3, 0);

        // SUB SP held by a 3-cycle stall
        step(0, 0, 0, 1, 16'hB080, 1, 13, 0);
        repeat (3) step(0, 1, 0, 1, 16'h1C01, 1, 13, 13);
        step(0, 0, 0, 0, 16'h0000, 1, 13, 0);

        // LDR r0 waiting for memory, with a stall during WAIT
        step(0, 0, 0, 1, 16'h6808, 0, 0, 1);
        step(0, 1, 0, 1, 16'h1C02, 0, 0, 1);
        step(0, 0, 0, 1, 16'h1C02, 0, 0, 1);
        step(0, 1, 0, 1, 16'h1C02, 0, 0, 1);
        step(0, 0, 0, 1, 16'h1C02, 1, 0, 1);
        step(0, 0, 0, 0, 16'h0000, 1, 0, 1);

        // Flush during WAIT, then flush together with ready
        step(0, 0, 0, 1, 16'h4A10, 0, 2, 0);
        step(0, 0, 0, 1, 16'h4A10, 0, 2, 0);
        step(0, 0, 1, 1, 16'h4A10, 0, 2, 0);
        step(0, 0, 0, 0, 16'h0000, 1, 2, 0);
        step(0, 0, 0, 1, 16'h6811, 0, 1, 0);
        step(0, 0, 1, 1, 16'h6811, 1, 1, 0);
        step(0, 0, 0, 0, 16'h0000, 1, 1, 0);

        // Hazard walk: MOV r2, ADD r5, ADD r1 against src_a = 2
        step(0, 0, 0, 1, 16'h2205, 1, 2, 5);
        step(0, 0, 0, 1, 16'h1C05, 1, 2, 5);
        step(0, 0, 0, 1, 16'h1C01, 1, 2, 5);
        step(0, 0, 0, 0, 16'h0000, 1, 2, 1);

        // Stalled bubble must not flag once its pulse has passed
        step(0, 0, 0, 1, 16'h1C02, 1, 2, 2);
        step(0, 1, 0, 1, 16'h1C03, 1, 2, 2);
        step(0, 0, 0, 1, 16'h1C03, 1, 2, 3);
        step(0, 0, 0, 1, 16'hFFFF, 1, 2, 3);

        // Reset while in WAIT
        step(0, 0, 0, 1, 16'h6808, 0, 0, 0);
        step(0, 0, 0, 1, 16'h6808, 0, 0, 0);
        step(1, 0, 0, 1, 16'h6808, 1, 0, 0);
        step(0, 0, 0, 0, 16'h0000, 1, 0, 0);

        // Randomised traffic
        repeat (3000) begin
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 7) != 0,
                 rand_ir(),
                 $urandom_range(0, 1) == 1,
                 RA_W'($urandom_range(0, 15)),
                 RA_W'($urandom_range(0, 15)));
        end

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ctrl_mem_pipe.md
# ctrl_mem_pipe

Parametrised MEM→WB pipeline control stage. It decodes the destination register and write enable from the MEM-stage instruction and registers them, together with the instruction, into WB. It also keeps a STAGES-deep history of retiring register writes and flags read-after-write hazards against two ID-stage source operands. It adds flush, valid gating and a multi-cycle load wait state with its own stall request.

## Interface
Parameters:
- RA_W, 4: register address width (≥4; SP address must fit).
- STAGES, 2: writeback history depth incl. stage 0 (1..4).
- SP_ADDR, 13: register address written by SUB SP.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_stall  in  1  downstream/global stall.
- i_flush  in  1  kill instruction entering or waiting in stage 0.
- i_valid  in  1  i_ir_mem holds a real instruction.
- i_ir_mem  in  16  MEM-stage instruction.
- i_mem_ready  in  1  data-memory load data available this cycle.
- i_src_a, i_src_b  in  RA_W  ID-stage source register addresses.
- o_ir_wb_r  out  16  WB-stage instruction.
- o_valid_wb_r  out  1  WB instruction valid.
- o_addr_rd_r  out  RA_W  WB destination register.
- o_rd_en_r  out  1  register-file write enable (one-cycle pulse per instruction).
- o_stall_req  out  1  high while state = WAIT (upstream must hold i_ir_mem).
- o_hazard_a, o_hazard_b  out  STAGES  bit k: history entry k writes i_src_a / i_src_b.

## Operation
- Decode on i_ir_mem[15:7] (? = don't care), addr zero-extended to RA_W:
  - 0001110??: ADD reg → rd = ir[2:0].
  - 10101????: ADD SP+imm → rd = ir[10:8].
  - 101100001: SUB SP → rd = SP_ADDR.
  - 00100????: MOV imm → rd = ir[10:8].
  - 01000110?: MOV reg → rd = ir[2:0].
  - 01101????: LDR → rd = ir[2:0]; load.
  - 01001????: LDR literal → rd = ir[10:8]; load.
  - other: rd = 0, no write.
- we_dec = i_valid & pattern match. load_dec = we_dec & LDR/LDR-literal.
- FSM states IDLE, WAIT. adv = (state==IDLE) & !i_stall & !i_flush.
- IDLE, adv: stage 0 ← {ir, i_valid, rd}. o_rd_en_r ← we_dec & !(load_dec & !i_mem_ready). History shifts: entry k ← entry k-1 (k ≥ 1).
- IDLE, adv, load_dec & !i_mem_ready: go to WAIT.
- IDLE, i_stall & !i_flush: o_rd_en_r ← 0 (no double write). ir, valid, addr and history hold.
- WAIT: ignores i_stall and i_ir_mem. Stage 0 and history hold.
- WAIT, i_mem_ready & !i_flush: o_rd_en_r ← 1, go to IDLE.
- i_flush, either state: o_ir_wb_r ← 0, o_valid_wb_r ← 0, o_rd_en_r ← 0, go to IDLE. History unchanged.
- Priority: rst > i_flush > i_mem_ready (WAIT) > i_stall.
- History entry k = {addr, en}. Entry 0 is the live WB register. Entry k ≥ 1 en = value of o_rd_en_r when shifted out, so stalled bubbles never create false hazards.
- o_hazard_a[k] = en_k & (addr_k == i_src_a); same for b. Combinational from registers and sources.

## Timing
- Reset: all outputs 0, all history entries 0, state IDLE. o_stall_req = 0.
- Latency i_ir_mem → o_* = 1 cycle for non-load and ready-at-issue loads.
- Load with ready at cycle N+d (d ≥ 1): o_stall_req high from cycle N+1 through the cycle ready is seen. o_rd_en_r pulses in the following cycle.
- o_stall_req is a registered-state decode with no combinational path from inputs.
- o_rd_en_r never high two consecutive cycles for the same instruction.
- Reset in WAIT returns to IDLE next cycle; no write is issued.

## Test plan
- ADD ir=0x1C53 (rd=3), valid, no stall → next cycle o_rd_en_r=1, o_addr_rd_r=3, o_ir_wb_r=0x1C53. Following cycle with an unknown opcode → o_rd_en_r=0.
- SUB SP 0xB080 followed by stall held 3 cycles → one o_rd_en_r pulse with addr 13. ir holds 0xB080 throughout the stall.
- LDR 0x6808 (rd=0) with i_mem_ready low 4 cycles → o_stall_req high 4 cycles, o_rd_en_r=0 during them. Single pulse after ready with addr 0. An i_stall during WAIT has no effect.
- Flush during WAIT, and flush simultaneous with i_mem_ready → no write, valid=0, state IDLE next cycle.
- STAGES=3: MOV imm 0x2205 (rd=2) then two ADDs writing r5 and r1, with i_src_a=2 → o_hazard_a = 001, 010, 100 on successive cycles. A bubble entry never flags.
- rst asserted mid-stream (incl. in WAIT) → all outputs, history and o_stall_req are 0 on the next cycle.
